// File: rtl/if_prefetch.sv
// Instruction fetch front end: issues req/gnt/rvalid bus fetches, buffers
// returned words with their addresses in a small FIFO, and presents one
// instruction per cycle to the IF/ID register. Jumps redirect the fetch PC,
// flush the FIFO and squash responses still in flight.
module if_prefetch #(
  parameter int unsigned DEPTH      = 3,
  parameter logic [31:0] RESET_ADDR = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  hold_flag_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  localparam logic [2:0]  HOLD_PC  = 3'b001;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   fetchPc_q, fetchPc_d;
  logic [31:0]   respPc_q, respPc_d;
  logic [31:0]   redirPc_q, redirPc_d;
  logic          redirPending_q, redirPending_d;
  logic          reqPending_q, reqPending_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [31:0]   addrMem_q [DEPTH];
  logic [31:0]   dataMem_q [DEPTH];

  logic        stall, creditOk, reqOut, gntFire, push, pop, headValid;
  logic [31:0] jumpPc;

  function automatic logic [PW-1:0] ptrNext(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign stall     = (hold_flag_i >= HOLD_PC);
  assign jumpPc    = jump_addr_i & 32'hFFFF_FFFC;
  assign creditOk  = ({1'b0, count_q} + {1'b0, outstanding_q}) < (CW + 1)'(DEPTH);
  assign reqOut    = ~rst_i & (reqPending_q | creditOk);
  assign gntFire   = reqOut & instr_gnt_i;
  assign push      = instr_rvalid_i & ~jump_flag_i & (discard_q == '0);
  assign pop       = (count_q != '0) & ~stall & ~jump_flag_i;
  assign headValid = (count_q != '0) & ~rst_i;

  assign instr_req_o  = reqOut;
  assign instr_addr_o = fetchPc_q;
  assign inst_valid_o = headValid;
  assign inst_o       = headValid ? dataMem_q[rdPtr_q] : INST_NOP;
  assign inst_addr_o  = headValid ? addrMem_q[rdPtr_q] : 32'h0;

  // Next-state for PCs, bus accounting, discard credit and FIFO pointers; a jump overrides everything else.
  always_comb begin
    fetchPc_d      = fetchPc_q;
    respPc_d       = respPc_q;
    redirPc_d      = redirPc_q;
    redirPending_d = redirPending_q;
    discard_d      = discard_q;
    count_d        = count_q;
    rdPtr_d        = rdPtr_q;
    wrPtr_d        = wrPtr_q;
    reqPending_d   = reqOut & ~instr_gnt_i;
    outstanding_d  = outstanding_q + CW'(gntFire) - CW'(instr_rvalid_i);

    if (jump_flag_i) begin
      count_d   = '0;
      rdPtr_d   = '0;
      wrPtr_d   = '0;
      respPc_d  = jumpPc;
      discard_d = outstanding_d;
      if (reqOut && !instr_gnt_i) begin
        redirPending_d = 1'b1;
        redirPc_d      = jumpPc;
      end else begin
        redirPending_d = 1'b0;
        fetchPc_d      = jumpPc;
      end
    end else begin
      if (gntFire) begin
        if (redirPending_q) begin
          fetchPc_d      = redirPc_q;
          redirPending_d = 1'b0;
        end else begin
          fetchPc_d = fetchPc_q + 32'd4;
        end
      end
      discard_d = discard_q
                  - CW'(instr_rvalid_i && (discard_q != '0))
                  + CW'(gntFire && redirPending_q);
      if (push) begin
        respPc_d = respPc_q + 32'd4;
        wrPtr_d  = ptrNext(wrPtr_q);
      end
      if (pop) begin
        rdPtr_d = ptrNext(rdPtr_q);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetchPc_q      <= RESET_ADDR;
      respPc_q       <= RESET_ADDR;
      redirPc_q      <= RESET_ADDR;
      redirPending_q <= 1'b0;
      reqPending_q   <= 1'b0;
      outstanding_q  <= '0;
      discard_q      <= '0;
      count_q        <= '0;
      rdPtr_q        <= '0;
      wrPtr_q        <= '0;
    end else begin
      fetchPc_q      <= fetchPc_d;
      respPc_q       <= respPc_d;
      redirPc_q      <= redirPc_d;
      redirPending_q <= redirPending_d;
      reqPending_q   <= reqPending_d;
      outstanding_q  <= outstanding_d;
      discard_q      <= discard_d;
      count_q        <= count_d;
      rdPtr_q        <= rdPtr_d;
      wrPtr_q        <= wrPtr_d;
    end
  end

  // FIFO storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addrMem_q[wrPtr_q] <= respPc_q;
      dataMem_q[wrPtr_q] <= instr_rdata_i;
    end
  end

  // The credit limit guarantees a kept response never lands in a full FIFO.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      assert (count_q < CW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench for if_prefetch: a bus model answers fetches with a
// hashed memory image, and a scoreboard queue holds the addresses the
// pipeline should consume next.
module tb_if_prefetch;

  localparam int          DEPTH      = 3;
  localparam logic [31:0] RESET_ADDR = 32'h0;
  localparam logic [2:0]  HOLD_PC    = 3'b001;
  localparam logic [31:0] INST_NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [2:0]  hold_flag_i = '0;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;

  always #5 clk = ~clk;

  if_prefetch #(.DEPTH(DEPTH), .RESET_ADDR(RESET_ADDR)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .hold_flag_i    (hold_flag_i),
    .jump_flag_i    (jump_flag_i),
    .jump_addr_i    (jump_addr_i),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .inst_o         (inst_o),
    .inst_addr_o    (inst_addr_o),
    .inst_valid_o   (inst_valid_o)
  );

  int checkCount = 0;
  int passCount  = 0;
  int cycle      = 0;
  int popCount   = 0;

  int   gntDelayMax = 0;
  int   rspFixed    = 0;
  int   rspRandMax  = 0;
  logic forceNoGnt  = 1'b0;
  int   gntWait     = 0;

  logic [31:0] busAddrQ[$];
  int          busDueQ[$];
  logic [31:0] expQ[$];
  logic [31:0] expNext = RESET_ADDR;

  logic        prevPending   = 1'b0;
  logic [31:0] prevBusAddr   = '0;
  logic        prevStallHead = 1'b0;
  logic [31:0] prevInst      = '0;
  logic [31:0] prevInstAddr  = '0;
  int          sinceJump     = 99;
  logic        expectJumpReq = 1'b0;
  logic        skipOne       = 1'b0;
  logic [31:0] jumpTgt       = '0;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cycle, observed, expected);
  endtask

  task automatic refillExp();
    while (expQ.size() < 4) begin
      expQ.push_back(expNext);
      expNext = expNext + 32'd4;
    end
  endtask

  task automatic setReset(input logic v);
    rst_i = v;
    #1;
  endtask

  // One clock cycle: observe and check outputs, run the bus and consumer
  // models, drive the inputs, then advance to just after the next edge.
  task automatic applyStimulus(input logic [2:0] hold, input logic jump, input logic [31:0] jaddr);
    logic        gnt, rv, stall;
    logic [31:0] rdata, exp;
    gnt   = 1'b0;
    rv    = 1'b0;
    rdata = '0;
    stall = (hold >= HOLD_PC);
    if (rst_i) begin
      checkOutput("rstReq", {31'b0, instr_req_o}, 32'd0);
      checkOutput("rstValid", {31'b0, inst_valid_o}, 32'd0);
      checkOutput("rstInst", inst_o, INST_NOP);
      checkOutput("rstInstAddr", inst_addr_o, 32'h0);
      busAddrQ.delete();
      busDueQ.delete();
      gntWait = 0;
      expQ.delete();
      expNext = RESET_ADDR;
      refillExp();
      prevPending   = 1'b0;
      prevStallHead = 1'b0;
      sinceJump     = 99;
      expectJumpReq = 1'b0;
      skipOne       = 1'b0;
      hold_flag_i    = '0;
      jump_flag_i    = 1'b0;
      jump_addr_i    = '0;
      instr_gnt_i    = 1'b0;
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = '0;
    end else begin
      if (prevPending) begin
        checkOutput("reqHeld", {31'b0, instr_req_o}, 32'd1);
        checkOutput("addrHeld", instr_addr_o, prevBusAddr);
      end
      checkOutput("credit", {31'b0, busAddrQ.size() <= DEPTH}, 32'd1);
      if (sinceJump == 1 || sinceJump == 2)
        checkOutput("jumpLatency", {31'b0, inst_valid_o}, 32'd0);
      if (expectJumpReq && instr_req_o && !skipOne) begin
        checkOutput("jumpReqAddr", instr_addr_o, jumpTgt);
        expectJumpReq = 1'b0;
      end
      if (prevStallHead) begin
        checkOutput("stallValid", {31'b0, inst_valid_o}, 32'd1);
        checkOutput("stallAddr", inst_addr_o, prevInstAddr);
        checkOutput("stallInst", inst_o, prevInst);
      end
      if (inst_valid_o) checkOutput("instData", inst_o, memWord(inst_addr_o));
      else checkOutput("emptyNop", inst_o, INST_NOP);

      if (instr_req_o && !forceNoGnt) begin
        if (gntWait == 0) begin
          gnt = 1'b1;
          gntWait = int'($urandom_range(gntDelayMax, 0));
        end else begin
          gntWait--;
        end
      end
      if (busAddrQ.size() > 0 && busDueQ[0] <= cycle) begin
        rv    = 1'b1;
        rdata = memWord(busAddrQ[0]);
        void'(busAddrQ.pop_front());
        void'(busDueQ.pop_front());
      end
      if (gnt) begin
        busAddrQ.push_back(instr_addr_o);
        busDueQ.push_back(cycle + 1 + rspFixed + int'($urandom_range(rspRandMax, 0)));
      end

      if (jump) begin
        expQ.delete();
        expNext = jaddr & 32'hFFFF_FFFC;
        refillExp();
        sinceJump     = 0;
        expectJumpReq = 1'b1;
        jumpTgt       = jaddr & 32'hFFFF_FFFC;
        skipOne       = instr_req_o && !gnt;
      end else begin
        if (inst_valid_o && !stall) begin
          exp = expQ.pop_front();
          checkOutput("instAddr", inst_addr_o, exp);
          refillExp();
          popCount++;
        end
        if (skipOne && gnt) skipOne = 1'b0;
      end

      prevStallHead = inst_valid_o && stall && !jump;
      prevInst      = inst_o;
      prevInstAddr  = inst_addr_o;
      prevPending   = instr_req_o && !gnt;
      prevBusAddr   = instr_addr_o;
      if (sinceJump < 99) sinceJump++;

      hold_flag_i    = hold;
      jump_flag_i    = jump;
      jump_addr_i    = jaddr;
      instr_gnt_i    = gnt;
      instr_rvalid_i = rv;
      instr_rdata_i  = rdata;
    end
    @(posedge clk);
    #1;
    cycle++;
  endtask

  // Runs cycles until the FIFO head is valid, then checks its address.
  task automatic waitValid(input string tag, input logic [31:0] expAddr);
    for (int n = 0; n < 40 && !inst_valid_o; n++) applyStimulus(3'b000, 1'b0, 32'h0);
    checkOutput({tag, "Valid"}, {31'b0, inst_valid_o}, 32'd1);
    checkOutput({tag, "Addr"}, inst_addr_o, expAddr);
  endtask

  // Runs cycles until the bus model holds the given number of owed responses.
  task automatic waitOutstanding(input int want);
    for (int n = 0; n < 20 && busAddrQ.size() != want; n++) applyStimulus(3'b000, 1'b0, 32'h0);
    checkOutput("outstandingReached", busAddrQ.size(), want);
  endtask

  initial begin
    logic [31:0] oldAddr;
    logic [2:0]  hold;
    logic        jump;
    logic [31:0] jaddr;

    // Reset, then zero-wait streaming.
    setReset(1'b1);
    applyStimulus(3'b000, 1'b0, 32'h0);
    applyStimulus(3'b000, 1'b0, 32'h0);
    setReset(1'b0);
    for (int k = 0; k < 12; k++) begin
      checkOutput("streamReq", {31'b0, instr_req_o}, 32'd1);
      checkOutput("streamAddr", instr_addr_o, 32'(4 * k));
      checkOutput("streamValid", {31'b0, inst_valid_o}, {31'b0, k >= 2});
      if (k >= 2) checkOutput("streamHead", inst_addr_o, 32'(4 * (k - 2)));
      applyStimulus(3'b000, 1'b0, 32'h0);
    end

    // Five-cycle stall mid-stream, then resume.
    for (int k = 0; k < 5; k++) applyStimulus((k < 3) ? HOLD_PC : 3'b011, 1'b0, 32'h0);
    for (int k = 0; k < 10; k++) applyStimulus(3'b000, 1'b0, 32'h0);

    // Jump to 0x103 with two requests outstanding.
    rspFixed = 2;
    waitOutstanding(2);
    applyStimulus(3'b000, 1'b1, 32'h0000_0103);
    waitValid("jumpFirst", 32'h0000_0100);
    rspFixed = 0;
    for (int k = 0; k < 10; k++) applyStimulus(3'b000, 1'b0, 32'h0);

    // Grant withheld three cycles, jump in the second.
    checkOutput("withheldReq", {31'b0, instr_req_o}, 32'd1);
    oldAddr    = instr_addr_o;
    forceNoGnt = 1'b1;
    applyStimulus(3'b000, 1'b0, 32'h0);
    applyStimulus(3'b000, 1'b1, 32'h0000_0200);
    applyStimulus(3'b000, 1'b0, 32'h0);
    forceNoGnt = 1'b0;
    checkOutput("withheldAddr", instr_addr_o, oldAddr);
    applyStimulus(3'b000, 1'b0, 32'h0);
    checkOutput("withheldNextReq", {31'b0, instr_req_o}, 32'd1);
    checkOutput("withheldNextAddr", instr_addr_o, 32'h0000_0200);
    waitValid("withheldFirst", 32'h0000_0200);
    for (int k = 0; k < 6; k++) applyStimulus(3'b000, 1'b0, 32'h0);

    // Reset mid-stream with two outstanding.
    rspFixed = 2;
    waitOutstanding(2);
    setReset(1'b1);
    applyStimulus(3'b000, 1'b0, 32'h0);
    setReset(1'b0);
    rspFixed = 0;
    checkOutput("postRstValid", {31'b0, inst_valid_o}, 32'd0);
    checkOutput("postRstInst", inst_o, INST_NOP);
    checkOutput("postRstReq", {31'b0, instr_req_o}, 32'd1);
    checkOutput("postRstAddr", instr_addr_o, RESET_ADDR);
    waitValid("postRstFirst", RESET_ADDR);

    // Random bus delays, stalls and jumps.
    gntDelayMax = 4;
    rspRandMax  = 4;
    popCount    = 0;
    for (int k = 0; k < 1500; k++) begin
      hold  = ($urandom_range(3, 0) == 0) ? 3'($urandom_range(7, 1)) : 3'b000;
      jump  = ($urandom_range(40, 0) == 0);
      jaddr = ($urandom_range(9, 0) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15, 0)))
                                          : ($urandom & 32'h0000_FFFF);
      applyStimulus(hold, jump, jaddr);
    end
    gntDelayMax = 0;
    rspRandMax  = 0;
    for (int k = 0; k < 20; k++) applyStimulus(3'b000, 1'b0, 32'h0);
    checkOutput("progress", {31'b0, popCount > 300}, 32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  // Guards against a hung run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
